// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the memory stage. The load/store unit uses them here,
// and the decoder uses the same store-width and load-extension encodings.
//   lsu_state_t : load/store unit sequencing states
//   storesrc_t  : store width select (B/H/W/D)
//   memext_t    : load width and sign/zero extension select
package riscv_pkg;

  // LSU sequencing. DRAIN absorbs the response of a load that was flushed
  // after its request had already been accepted.
  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_REQ   = 3'd1,
    LSU_WAIT  = 3'd2,
    LSU_DONE  = 3'd3,
    LSU_DRAIN = 3'd4
  } lsu_state_t;

  typedef enum logic [1:0] {
    STORE_B = 2'b00,
    STORE_H = 2'b01,
    STORE_W = 2'b10,
    STORE_D = 2'b11
  } storesrc_t;

  typedef enum logic [2:0] {
    MEMEXT_LB  = 3'b000,
    MEMEXT_LH  = 3'b001,
    MEMEXT_LW  = 3'b010,
    MEMEXT_LD  = 3'b011,
    MEMEXT_LBU = 3'b100,
    MEMEXT_LHU = 3'b101,
    MEMEXT_LWU = 3'b110
  } memext_t;

endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align
// Combinational byte-lane logic for the load/store unit.
//   i_align_offset    : address bits [2:0], the byte lane within the doubleword
//   i_align_storesrc  : store width (storesrc_t encoding)
//   i_align_storedata : LSB-aligned store data
//   i_align_memext    : load width/extension (memext_t encoding)
//   i_align_rdata     : aligned doubleword returned by memory
//   o_align_wdata     : store data moved up to its byte lane
//   o_align_wstrb     : byte enables for the store
//   o_align_loadext   : selected load lane, sign- or zero-extended to 64 bits
module riscv_lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  i_align_offset,
  input  logic [1:0]  i_align_storesrc,
  input  logic [63:0] i_align_storedata,
  input  logic [2:0]  i_align_memext,
  input  logic [63:0] i_align_rdata,
  output logic [63:0] o_align_wdata,
  output logic [7:0]  o_align_wstrb,
  output logic [63:0] o_align_loadext
);

  logic [5:0]  w_bit_shift;
  logic [7:0]  w_base_strb;
  logic [63:0] w_lane;

  // The byte offset becomes a bit offset by appending three zero bits.
  assign w_bit_shift = {i_align_offset, 3'b000};

  // Byte-enable pattern for a store of the given width before lane placement.
  always_comb begin
    w_base_strb = 8'h01;
    case (storesrc_t'(i_align_storesrc))
      STORE_B: w_base_strb = 8'h01;
      STORE_H: w_base_strb = 8'h03;
      STORE_W: w_base_strb = 8'h0F;
      STORE_D: w_base_strb = 8'hFF;
    endcase
  end

  assign o_align_wstrb = w_base_strb << i_align_offset;
  assign o_align_wdata = i_align_storedata << w_bit_shift;

  // Bring the addressed lane down to bit 0, then keep only the loaded width
  // and fill the upper bits with either the lane's sign bit or zeros.
  assign w_lane = i_align_rdata >> w_bit_shift;

  always_comb begin
    o_align_loadext = w_lane;
    case (memext_t'(i_align_memext))
      MEMEXT_LB:  o_align_loadext = {{56{w_lane[7]}},  w_lane[7:0]};
      MEMEXT_LH:  o_align_loadext = {{48{w_lane[15]}}, w_lane[15:0]};
      MEMEXT_LW:  o_align_loadext = {{32{w_lane[31]}}, w_lane[31:0]};
      MEMEXT_LD:  o_align_loadext = w_lane;
      MEMEXT_LBU: o_align_loadext = {56'd0, w_lane[7:0]};
      MEMEXT_LHU: o_align_loadext = {48'd0, w_lane[15:0]};
      MEMEXT_LWU: o_align_loadext = {32'd0, w_lane[31:0]};
      default:    o_align_loadext = w_lane;
    endcase
  end

endmodule

// File: rtl/riscv_mem_lsu.sv
// riscv_mem_lsu
// Memory-stage load/store unit. It takes the EX/MEM register outputs, runs one
// data-memory access over a valid/ready request plus response-valid return,
// and holds the pipeline through o_riscv_lsu_stall until the access completes.
//   i_riscv_lsu_clk / i_riscv_lsu_rst_n : clock, synchronous active-low reset
//   i_riscv_lsu_load_m / _store_m        : memory operation in MEM stage
//   i_riscv_lsu_storesrc_m / _memext_m   : store width, load width/extension
//   i_riscv_lsu_addr_m / _storedata_m    : effective address, store data
//   i_riscv_lsu_trap_m / _flush          : instruction traps, pipeline flush
//   o_riscv_lsu_stall                    : hold EX/MEM and earlier stages
//   o_riscv_lsu_loaddata                 : registered, extended load result
//   o_riscv_lsu_req_* / i_riscv_lsu_req_ready : request channel
//   i_riscv_lsu_rsp_valid / i_riscv_lsu_rdata : read response channel
module riscv_mem_lsu
  import riscv_pkg::*;
(
  input  logic        i_riscv_lsu_clk,
  input  logic        i_riscv_lsu_rst_n,
  input  logic        i_riscv_lsu_load_m,
  input  logic        i_riscv_lsu_store_m,
  input  logic [1:0]  i_riscv_lsu_storesrc_m,
  input  logic [2:0]  i_riscv_lsu_memext_m,
  input  logic [63:0] i_riscv_lsu_addr_m,
  input  logic [63:0] i_riscv_lsu_storedata_m,
  input  logic        i_riscv_lsu_trap_m,
  input  logic        i_riscv_lsu_flush,
  output logic        o_riscv_lsu_stall,
  output logic [63:0] o_riscv_lsu_loaddata,
  output logic        o_riscv_lsu_req_valid,
  input  logic        i_riscv_lsu_req_ready,
  output logic [63:0] o_riscv_lsu_req_addr,
  output logic        o_riscv_lsu_req_we,
  output logic [63:0] o_riscv_lsu_req_wdata,
  output logic [7:0]  o_riscv_lsu_req_wstrb,
  input  logic        i_riscv_lsu_rsp_valid,
  input  logic [63:0] i_riscv_lsu_rdata
);

  lsu_state_t  r_state;
  lsu_state_t  w_next_state;
  logic [63:0] r_loaddata;
  logic        w_access;
  logic        w_req_valid;
  logic        w_load_commit;
  logic [63:0] w_wdata_aligned;
  logic [7:0]  w_wstrb_aligned;
  logic [63:0] w_load_ext;

  // A trapping or flushed instruction must never touch memory.
  assign w_access = (i_riscv_lsu_load_m | i_riscv_lsu_store_m) &
                    ~i_riscv_lsu_trap_m & ~i_riscv_lsu_flush;

  riscv_lsu_align u_align (
    .i_align_offset    (i_riscv_lsu_addr_m[2:0]),
    .i_align_storesrc  (i_riscv_lsu_storesrc_m),
    .i_align_storedata (i_riscv_lsu_storedata_m),
    .i_align_memext    (i_riscv_lsu_memext_m),
    .i_align_rdata     (i_riscv_lsu_rdata),
    .o_align_wdata     (w_wdata_aligned),
    .o_align_wstrb     (w_wstrb_aligned),
    .o_align_loadext   (w_load_ext)
  );

  // State register. Reset abandons any access in flight; a response that
  // arrives later for it is simply ignored in IDLE.
  always_ff @(posedge i_riscv_lsu_clk) begin
    if (!i_riscv_lsu_rst_n) begin
      r_state <= LSU_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and request-valid decode. A flush in REQ withdraws the request
  // in the same cycle so it can never be accepted. A flush in WAIT leaves a
  // response outstanding, which DRAIN swallows, unless that response arrives
  // in the flush cycle itself, in which case there is nothing left to drain.
  always_comb begin
    w_next_state = r_state;
    w_req_valid  = 1'b0;
    case (r_state)
      LSU_IDLE: begin
        if (w_access) begin
          w_next_state = LSU_REQ;
        end
      end
      LSU_REQ: begin
        if (i_riscv_lsu_flush) begin
          w_next_state = LSU_IDLE;
        end else begin
          w_req_valid = 1'b1;
          if (i_riscv_lsu_req_ready) begin
            w_next_state = i_riscv_lsu_store_m ? LSU_DONE : LSU_WAIT;
          end
        end
      end
      LSU_WAIT: begin
        if (i_riscv_lsu_flush) begin
          w_next_state = i_riscv_lsu_rsp_valid ? LSU_IDLE : LSU_DRAIN;
        end else if (i_riscv_lsu_rsp_valid) begin
          w_next_state = LSU_DONE;
        end
      end
      LSU_DONE: begin
        w_next_state = LSU_IDLE;
      end
      LSU_DRAIN: begin
        if (i_riscv_lsu_rsp_valid) begin
          w_next_state = LSU_IDLE;
        end
      end
      default: begin
        w_next_state = LSU_IDLE;
      end
    endcase
  end

  // Load data is captured only when a live load's response arrives, so the
  // value seen in DONE belongs to the instruction leaving the stage.
  assign w_load_commit = (r_state == LSU_WAIT) & i_riscv_lsu_rsp_valid &
                         ~i_riscv_lsu_flush;

  always_ff @(posedge i_riscv_lsu_clk) begin
    if (!i_riscv_lsu_rst_n) begin
      r_loaddata <= 64'd0;
    end else if (w_load_commit) begin
      r_loaddata <= w_load_ext;
    end
  end

  // The pipeline is released only in DONE; DRAIN stalls regardless of what
  // the next instruction is, so it cannot request until the bus is quiet.
  assign o_riscv_lsu_stall = (w_access & (r_state != LSU_DONE)) |
                             (r_state == LSU_DRAIN);

  // Request fields come straight from the held EX/MEM register and are
  // forced to zero whenever no request is being presented.
  assign o_riscv_lsu_req_valid = w_req_valid;
  assign o_riscv_lsu_req_addr  = w_req_valid ? {i_riscv_lsu_addr_m[63:3], 3'b000} : 64'd0;
  assign o_riscv_lsu_req_we    = w_req_valid & i_riscv_lsu_store_m;
  assign o_riscv_lsu_req_wdata = w_req_valid ? w_wdata_aligned : 64'd0;
  assign o_riscv_lsu_req_wstrb = w_req_valid ? w_wstrb_aligned : 8'd0;
  assign o_riscv_lsu_loaddata  = r_loaddata;

endmodule

// File: tb/tb_riscv_mem_lsu.sv
// tb_riscv_mem_lsu
// Scoreboard bench for riscv_mem_lsu. The driver pushes the expected bus
// request and the expected post-instruction load data into queues; a monitor
// pops and compares them whenever the DUT issues a request or releases the
// pipeline. Expected values come from a byte-lane reference model.
module tb_riscv_mem_lsu;

  logic        clk = 1'b0;
  logic        rstN;
  logic        loadM;
  logic        storeM;
  logic [1:0]  storeSrc;
  logic [2:0]  memExt;
  logic [63:0] addrM;
  logic [63:0] storeData;
  logic        trapM;
  logic        flush;
  logic        stall;
  logic [63:0] loadData;
  logic        reqValid;
  logic        reqReady;
  logic [63:0] reqAddr;
  logic        reqWe;
  logic [63:0] reqWdata;
  logic [7:0]  reqWstrb;
  logic        rspValid;
  logic [63:0] rdata;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } reqExp_t;

  reqExp_t     reqQ[$];
  logic [63:0] doneQ[$];
  logic [63:0] modelLoadData;
  int          vecCount;
  int          missCount;

  always #5 clk = ~clk;

  riscv_mem_lsu dut (
    .i_riscv_lsu_clk         (clk),
    .i_riscv_lsu_rst_n       (rstN),
    .i_riscv_lsu_load_m      (loadM),
    .i_riscv_lsu_store_m     (storeM),
    .i_riscv_lsu_storesrc_m  (storeSrc),
    .i_riscv_lsu_memext_m    (memExt),
    .i_riscv_lsu_addr_m      (addrM),
    .i_riscv_lsu_storedata_m (storeData),
    .i_riscv_lsu_trap_m      (trapM),
    .i_riscv_lsu_flush       (flush),
    .o_riscv_lsu_stall       (stall),
    .o_riscv_lsu_loaddata    (loadData),
    .o_riscv_lsu_req_valid   (reqValid),
    .i_riscv_lsu_req_ready   (reqReady),
    .o_riscv_lsu_req_addr    (reqAddr),
    .o_riscv_lsu_req_we      (reqWe),
    .o_riscv_lsu_req_wdata   (reqWdata),
    .o_riscv_lsu_req_wstrb   (reqWstrb),
    .i_riscv_lsu_rsp_valid   (rspValid),
    .i_riscv_lsu_rdata       (rdata)
  );

  // One comparison: counts it, and reports it if actual differs from expected.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Reference load: take nb bytes starting at byte offset off, then sign- or
  // zero-extend them to 64 bits.
  function automatic logic [63:0] modelLoad(input logic [63:0] data, input int off,
                                            input int ext);
    int          nb;
    bit          sgn;
    logic [63:0] v;
    logic [63:0] mask;
    nb  = 1 << (ext % 4);
    sgn = (ext < 3);
    v   = data >> (8 * off);
    if (nb < 8) begin
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v    = v & mask;
      if (sgn && v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // Monitor: every accepted request and every pipeline release is checked
  // against the oldest expectation in its queue.
  task automatic monitorProc();
    reqExp_t     e;
    logic [63:0] expLd;
    forever begin
      @(negedge clk);
      if (rstN) begin
        if (reqValid && reqReady) begin
          if (reqQ.size() == 0) begin
            checkOutput("unexpectedReq", 64'd1, 64'd0);
          end else begin
            e = reqQ.pop_front();
            checkOutput("reqAddr", reqAddr, e.addr);
            checkOutput("reqWe", {63'd0, reqWe}, {63'd0, e.we});
            if (e.we) begin
              checkOutput("reqWdata", reqWdata, e.wdata);
              checkOutput("reqWstrb", {56'd0, reqWstrb}, {56'd0, e.wstrb});
            end
          end
        end
        if ((loadM || storeM) && !trapM && !flush && !stall) begin
          if (doneQ.size() == 0) begin
            checkOutput("unexpectedDone", 64'd1, 64'd0);
          end else begin
            expLd = doneQ.pop_front();
            checkOutput("loadData", loadData, expLd);
          end
        end
      end
    end
  endtask

  // Runs one load or store to completion. Entered and left at posedge+1.
  // drainCycles > 0 means the unit is still draining a flushed load whose
  // response arrives in cycle drainCycles-1.
  task automatic applyStimulus(input bit isStore, input int sel, input logic [63:0] a,
                               input logic [63:0] d, input logic [63:0] rd,
                               input int readyDelay, input int rspDelay,
                               input int drainCycles);
    reqExp_t     e;
    logic [63:0] expLd;
    int          off;
    int          nb;
    int          cycle;
    int          hs;
    int          stalls;
    int          expStalls;
    bit          done;
    off     = int'(a[2:0]);
    e.addr  = {a[63:3], 3'b000};
    e.we    = isStore;
    e.wdata = 64'd0;
    e.wstrb = 8'd0;
    if (isStore) begin
      nb      = 1 << sel;
      e.wdata = d << (8 * off);
      e.wstrb = 8'(((1 << nb) - 1) << off);
      expLd   = modelLoadData;
      expStalls = drainCycles + 2 + readyDelay;
    end else begin
      expLd   = modelLoad(rd, off, sel);
      expStalls = drainCycles + 2 + readyDelay + rspDelay;
    end
    reqQ.push_back(e);
    doneQ.push_back(expLd);
    modelLoadData = expLd;

    loadM     = !isStore;
    storeM    = isStore;
    storeSrc  = isStore ? 2'(sel) : 2'($urandom_range(0, 3));
    memExt    = isStore ? 3'($urandom_range(0, 6)) : 3'(sel);
    addrM     = a;
    storeData = isStore ? d : rand64();
    trapM     = 1'b0;
    flush     = 1'b0;

    cycle = 0; hs = -1; stalls = 0; done = 1'b0;
    while (!done) begin
      reqReady = (cycle >= drainCycles + 1 + readyDelay);
      if (drainCycles > 0 && cycle == drainCycles - 1) begin
        rspValid = 1'b1; rdata = rand64();
      end else if (!isStore && hs >= 0 && cycle == hs + rspDelay) begin
        rspValid = 1'b1; rdata = rd;
      end else if (hs < 0 && cycle >= drainCycles) begin
        rspValid = 1'($urandom_range(0, 1)); rdata = rand64();
      end else begin
        rspValid = 1'b0; rdata = rand64();
      end
      @(negedge clk);
      if (drainCycles > 0 && cycle <= drainCycles)
        checkOutput("earlyReq", {63'd0, reqValid}, 64'd0);
      if (stall) stalls++;
      if (reqValid && reqReady) hs = cycle;
      if (!stall) begin
        done = 1'b1;
      end else if (cycle >= 80) begin
        checkOutput("opTimeout", 64'd1, 64'd0);
        done = 1'b1;
      end
      @(posedge clk); #1;
      cycle++;
    end
    loadM = 1'b0; storeM = 1'b0; rspValid = 1'b0;
    checkOutput("stallCycles", 64'(stalls), 64'(expStalls));
  endtask

  // A trapping load or store must stay off the bus and not stall.
  task automatic trapOp(input logic [63:0] a);
    loadM = 1'($urandom_range(0, 1)); storeM = !loadM; trapM = 1'b1;
    addrM = a; storeData = rand64(); reqReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rspValid = 1'($urandom_range(0, 1)); rdata = rand64();
      @(negedge clk);
      checkOutput("trapStall", {63'd0, stall}, 64'd0);
      checkOutput("trapReqValid", {63'd0, reqValid}, 64'd0);
      @(posedge clk); #1;
    end
    checkOutput("trapLoadData", loadData, modelLoadData);
    loadM = 1'b0; storeM = 1'b0; trapM = 1'b0; rspValid = 1'b0;
  endtask

  // Load flushed in its first WAIT cycle. mode 0: response 2 cycles after the
  // flush is drained. mode 1: response with the flush, no drain. mode 2:
  // returns in the first DRAIN cycle so the caller can present a new access.
  task automatic flushLoad(input logic [63:0] a, input int ext, input int readyDelay,
                           input int mode);
    reqExp_t e;
    int      cycle;
    bit      hs;
    e.addr = {a[63:3], 3'b000}; e.we = 1'b0; e.wdata = 64'd0; e.wstrb = 8'd0;
    reqQ.push_back(e);
    loadM = 1'b1; storeM = 1'b0; memExt = 3'(ext); addrM = a;
    storeData = rand64(); trapM = 1'b0; flush = 1'b0; rspValid = 1'b0;
    cycle = 0; hs = 1'b0;
    while (!hs) begin
      reqReady = (cycle >= 1 + readyDelay);
      @(negedge clk);
      if (reqValid && reqReady) begin
        hs = 1'b1;
      end else if (cycle >= 50) begin
        checkOutput("flushHsTimeout", 64'd1, 64'd0);
        hs = 1'b1;
      end
      @(posedge clk); #1;
      cycle++;
    end
    flush = 1'b1; reqReady = 1'b1;
    if (mode == 1) begin rspValid = 1'b1; rdata = rand64(); end
    @(negedge clk);
    checkOutput("flushStall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; loadM = 1'b0; rspValid = 1'b0;
    if (mode == 2) return;
    if (mode == 0) begin
      @(negedge clk);
      checkOutput("drainStall", {63'd0, stall}, 64'd1);
      @(posedge clk); #1;
      rspValid = 1'b1; rdata = rand64();
      @(negedge clk);
      checkOutput("drainStall", {63'd0, stall}, 64'd1);
      @(posedge clk); #1;
      rspValid = 1'b0;
    end
    @(negedge clk);
    checkOutput("postFlushStall", {63'd0, stall}, 64'd0);
    checkOutput("postFlushLoadData", loadData, modelLoadData);
    @(posedge clk); #1;
  endtask

  initial begin
    int          kind;
    int          sz;
    int          ext;
    logic [63:0] a;
    vecCount = 0; missCount = 0; modelLoadData = 64'd0;
    rstN = 1'b0; loadM = 1'b0; storeM = 1'b0; storeSrc = 2'd0; memExt = 3'd0;
    addrM = 64'd0; storeData = 64'd0; trapM = 1'b0; flush = 1'b0;
    reqReady = 1'b0; rspValid = 1'b0; rdata = 64'd0;
    fork
      monitorProc();
    join_none
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk);
    checkOutput("rstStall", {63'd0, stall}, 64'd0);
    checkOutput("rstReqValid", {63'd0, reqValid}, 64'd0);
    checkOutput("rstReqWe", {63'd0, reqWe}, 64'd0);
    checkOutput("rstReqAddr", reqAddr, 64'd0);
    checkOutput("rstReqWdata", reqWdata, 64'd0);
    checkOutput("rstReqWstrb", {56'd0, reqWstrb}, 64'd0);
    checkOutput("rstLoadData", loadData, 64'd0);
    @(posedge clk); #1;

    // Directed cases from the test plan.
    applyStimulus(1'b1, 3, 64'h1000, 64'hDEADBEEF_CAFEBABE, 64'd0, 0, 1, 0);
    applyStimulus(1'b1, 0, 64'h1003, 64'h0000_0000_0000_00AB, 64'd0, 0, 1, 0);
    applyStimulus(1'b0, 0, 64'h2005, 64'd0, 64'h0000_8000_0000_0000, 0, 1, 0);
    applyStimulus(1'b0, 4, 64'h2005, 64'd0, 64'h0000_8000_0000_0000, 0, 1, 0);
    applyStimulus(1'b0, 6, 64'h2004, 64'd0, 64'h8000_0001_1234_5678, 0, 1, 0);
    applyStimulus(1'b0, 3, 64'h3000, 64'd0, 64'h0123_4567_89AB_CDEF, 3, 2, 0);
    trapOp(64'h4008);
    flushLoad(64'h5000, 3, 0, 0);
    flushLoad(64'h5008, 2, 1, 2);
    applyStimulus(1'b0, 1, 64'h6002, 64'd0, rand64(), 0, 1, 2);
    flushLoad(64'h7000, 0, 0, 1);
    applyStimulus(1'b1, 2, 64'h7004, rand64(), 64'd0, 0, 1, 0);

    // Randomized mix of accesses, traps and flushes.
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      a    = rand64();
      if (kind <= 3) begin
        sz = $urandom_range(0, 3);
        a[2:0] = 3'(($urandom_range(0, 7) >> sz) << sz);
        applyStimulus(1'b1, sz, a, rand64(), 64'd0, $urandom_range(0, 3), 1, 0);
      end else if (kind <= 7) begin
        ext = $urandom_range(0, 6);
        sz  = ext % 4;
        a[2:0] = 3'(($urandom_range(0, 7) >> sz) << sz);
        applyStimulus(1'b0, ext, a, 64'd0, rand64(), $urandom_range(0, 3),
                      $urandom_range(1, 3), 0);
      end else if (kind == 8) begin
        trapOp(a);
      end else begin
        sz = $urandom_range(0, 2);
        flushLoad(a, $urandom_range(0, 6), $urandom_range(0, 2), sz);
        if (sz == 2) begin
          a[2:0] = 3'd0;
          applyStimulus(1'b0, 3, a, 64'd0, rand64(), $urandom_range(0, 2),
                        $urandom_range(1, 2), 2);
        end
      end
      repeat ($urandom_range(0, 2)) begin
        rspValid = 1'($urandom_range(0, 1)); rdata = rand64();
        reqReady = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      rspValid = 1'b0;
    end

    repeat (2) @(posedge clk);
    checkOutput("reqQueueEmpty", 64'(reqQ.size()), 64'd0);
    checkOutput("doneQueueEmpty", 64'(doneQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
